// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the multi-byte ALU sequencer.
// Also used by the control unit and benches that build ALU control bytes.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int NBYTES_DEFAULT = 2;

  // Control byte layout: [3:0] ALU function, [4] ALU honours carry-in.
  localparam logic [7:0] CINS_ADD  = 8'h01;
  localparam logic [7:0] CINS_ADDC = 8'h11;
  localparam logic [7:0] CINS_SUBC = 8'h12;

endpackage

// File: rtl/alu_seq.sv
// Drives an external 8-bit ALU one byte per cycle (LSB first), chaining carry and building whole-word flags.
// Optional macro ALU_SEQ_HOLD_EN: adds result_ready and holds DONE until it is seen high.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic [7:0]          op_cins,
  input  logic                carry_in,
`ifdef ALU_SEQ_HOLD_EN
  input  logic                result_ready,
`endif
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [7:0]          alu_cins,
  output logic                alu_oe,
  output logic                alu_carryin,
  input  logic [7:0]          alu_out,
  input  logic                alu_carryout,
  input  logic                alu_overout,
  input  logic                alu_cmpo,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                flag_c,
  output logic                flag_v,
  output logic                flag_z,
  output logic                flag_n,
  output logic                flag_cmp
);

  localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  state_e                 state_q, state_d;
  logic [NBYTES-1:0][7:0] a_q, b_q, res_q;
  logic [7:0]             cins_q;
  logic [IDXW-1:0]        idx_q;
  logic                   carry_q;
  logic                   z_acc_q;
  logic                   flag_c_q, flag_v_q, flag_z_q, flag_n_q, flag_cmp_q;

  logic in_run;
  logic last_byte;
  logic out_zero;

  assign in_run    = (state_q == RUN);
  assign last_byte = (idx_q == LAST_IDX);
  assign out_zero  = (alu_out == 8'd0);

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_byte) state_d = DONE;
      DONE: begin
`ifdef ALU_SEQ_HOLD_EN
        if (result_ready) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    alu_a       = 8'd0;
    alu_b       = 8'd0;
    alu_cins    = 8'd0;
    alu_oe      = 1'b0;
    alu_carryin = 1'b0;
    if (in_run) begin
      alu_a       = a_q[idx_q];
      alu_b       = b_q[idx_q];
      alu_cins    = cins_q;
      alu_oe      = 1'b1;
      alu_carryin = carry_q;
    end
  end

  assign busy     = in_run;
  assign done     = (state_q == DONE);
  assign result   = res_q;
  assign flag_c   = flag_c_q;
  assign flag_v   = flag_v_q;
  assign flag_z   = flag_z_q;
  assign flag_n   = flag_n_q;
  assign flag_cmp = flag_cmp_q;

  // NOTE: operand and result registers are small and reset explicitly so
  // outputs read zero after reset; this is not a RAM, so reset costs nothing.
  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      cins_q     <= 8'd0;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      z_acc_q    <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_v_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_n_q   <= 1'b0;
      flag_cmp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        a_q     <= op_a;
        b_q     <= op_b;
        cins_q  <= op_cins;
        carry_q <= carry_in;
        idx_q   <= '0;
        z_acc_q <= 1'b1;
      end else if (in_run) begin
        res_q[idx_q] <= alu_out;
        carry_q      <= alu_carryout;
        z_acc_q      <= z_acc_q & out_zero;
        if (last_byte) begin
          // The MSB byte supplies the signed/compare view of the whole word.
          flag_c_q   <= alu_carryout;
          flag_v_q   <= alu_overout;
          flag_n_q   <= alu_out[7];
          flag_cmp_q <= alu_cmpo;
          flag_z_q   <= z_acc_q & out_zero;
        end else begin
          idx_q <= idx_q + IDXW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: drives it together with a behavioural 8-bit ALU
// and compares against a whole-word arithmetic reference model.
`timescale 1ns/1ps
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int NB = NBYTES_DEFAULT;
  localparam int W  = 8 * NB;
  localparam logic [7:0] CINS_AND = 8'h03;
  localparam logic [7:0] CINS_XOR = 8'h04;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [7:0]   op_cins = 8'd0;
  logic         carry_in = 1'b0;
`ifdef ALU_SEQ_HOLD_EN
  logic         result_ready = 1'b1;
`endif
  logic [7:0]   alu_a, alu_b, alu_cins, alu_out;
  logic         alu_oe, alu_carryin, alu_carryout, alu_overout, alu_cmpo;
  logic         busy, done;
  logic [W-1:0] result;
  logic         flag_c, flag_v, flag_z, flag_n, flag_cmp;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(NB)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b), .op_cins(op_cins), .carry_in(carry_in),
`ifdef ALU_SEQ_HOLD_EN
    .result_ready(result_ready),
`endif
    .alu_a(alu_a), .alu_b(alu_b), .alu_cins(alu_cins), .alu_oe(alu_oe),
    .alu_carryin(alu_carryin), .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overout(alu_overout), .alu_cmpo(alu_cmpo),
    .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_v(flag_v), .flag_z(flag_z), .flag_n(flag_n), .flag_cmp(flag_cmp)
  );

  // Neighbouring 8-bit ALU: bit 4 of the control byte selects whether carry-in is used.
  logic [7:0] alu_bb;
  logic [8:0] alu_sum;
  logic       alu_cin_eff;
  always_comb begin
    alu_cin_eff  = alu_cins[4] & alu_carryin;
    alu_bb       = (alu_cins[3:0] == 4'h2) ? ~alu_b : alu_b;
    alu_sum      = {1'b0, alu_a} + {1'b0, alu_bb} + {8'd0, alu_cin_eff};
    alu_out      = 8'd0;
    alu_carryout = 1'b0;
    alu_overout  = 1'b0;
    alu_cmpo     = 1'b0;
    if (alu_oe) begin
      alu_cmpo = (alu_a == alu_b);
      case (alu_cins[3:0])
        4'h1, 4'h2: begin
          alu_out      = alu_sum[7:0];
          alu_carryout = alu_sum[8];
          alu_overout  = (alu_a[7] == alu_bb[7]) && (alu_sum[7] != alu_a[7]);
        end
        4'h3:    alu_out = alu_a & alu_b;
        4'h4:    alu_out = alu_a ^ alu_b;
        default: alu_out = 8'd0;
      endcase
    end
  end

  typedef struct packed {
    logic [W-1:0] r;
    logic c, v, z, n, cmp;
  } ref_t;

  // Word-level reference: carry-honouring ops are plain W-bit arithmetic;
  // CINS_ADD ignores carry, so each byte is an independent 8-bit add.
  function automatic ref_t ref_op(input logic [7:0] cins, input logic [W-1:0] a, b, input logic cin);
    ref_t o;
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic [8:0]   s9;
    o = '0;
    case (cins)
      CINS_ADDC, CINS_SUBC: begin
        bb   = (cins == CINS_SUBC) ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        o.r  = full[W-1:0];
        o.c  = full[W];
        o.v  = (a[W-1] == bb[W-1]) && (o.r[W-1] != a[W-1]);
      end
      CINS_ADD: begin
        for (int i = 0; i < NB; i++) begin
          s9 = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8]};
          o.r[i*8 +: 8] = s9[7:0];
          if (i == NB - 1) begin
            o.c = s9[8];
            o.v = (a[i*8+7] == b[i*8+7]) && (s9[7] != a[i*8+7]);
          end
        end
      end
      CINS_AND: o.r = a & b;
      CINS_XOR: o.r = a ^ b;
      default:  o.r = '0;
    endcase
    o.z   = (o.r == '0);
    o.n   = o.r[W-1];
    o.cmp = (a[W-1 -: 8] == b[W-1 -: 8]);
    return o;
  endfunction

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input ref_t e);
    check({tag, " result"}, 64'(result), 64'(e.r));
    check({tag, " flags cvznp"}, 64'({flag_c, flag_v, flag_z, flag_n, flag_cmp}),
          64'({e.c, e.v, e.z, e.n, e.cmp}));
  endtask

  // Issues one operation and returns at the negedge where done is first seen.
  task automatic run_op(input string tag, input logic [7:0] cins, input logic [W-1:0] a, b,
                        input logic cin, output logic cin1);
    logic seen;
    seen = 1'b0;
    cin1 = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; op_cins = cins; carry_in = cin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= NB + 4 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        check({tag, " latency"}, 64'(n), 64'(NB + 1));
      end else if (n <= NB) begin
        check({tag, " busy/alu_a"}, 64'({busy, alu_a}), 64'({1'b1, a[(n-1)*8 +: 8]}));
        if (n == 2) cin1 = alu_carryin;
      end
    end
    if (!seen) check({tag, " done timeout"}, 64'd0, 64'd1);
  endtask

  task automatic expect_drop(input string tag);
    @(negedge clk);
    check({tag, " done/busy after"}, 64'({done, busy}), 64'd0);
  endtask

  typedef struct packed {
    logic [7:0]   cins;
    logic [W-1:0] a, b;
    logic         cin;
    logic [W-1:0] r;
    logic         c, v, z, n, cmp, cin1;
  } vec_t;

  vec_t   vecs[7];
  ref_t   e;
  logic   cin1;
  int     dones;
  logic [7:0] pick[5];

  initial begin
    //           cins       a        b        cin  result   c     v     z     n     cmp   cin1
    vecs[0] = '{CINS_ADDC, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{CINS_ADDC, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{CINS_ADDC, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{CINS_SUBC, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{CINS_SUBC, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{CINS_ADD,  16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{CINS_SUBC, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    pick = '{CINS_ADD, CINS_ADDC, CINS_SUBC, CINS_AND, CINS_XOR};

    // Reset state
    #2;
    check("reset outputs", 64'({result, flag_c, flag_v, flag_z, flag_n, flag_cmp, busy, done}), 64'd0);
    check("reset alu bus", 64'({alu_a, alu_b, alu_cins, alu_oe, alu_carryin}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].cins, vecs[i].a, vecs[i].b, vecs[i].cin, cin1);
      check_outputs($sformatf("vec%0d", i),
                    '{r: vecs[i].r, c: vecs[i].c, v: vecs[i].v, z: vecs[i].z, n: vecs[i].n, cmp: vecs[i].cmp});
      check($sformatf("vec%0d byte1 carryin", i), 64'(cin1), 64'(vecs[i].cin1));
      expect_drop($sformatf("vec%0d", i));
    end

    // Random operations against the word-level model
    for (int i = 0; i < 40; i++) begin
      logic [7:0]   c8;
      logic [W-1:0] ra, rb;
      logic         rc;
      c8 = pick[$urandom_range(4, 0)];
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      e  = ref_op(c8, ra, rb, rc);
      run_op($sformatf("rnd%0d", i), c8, ra, rb, rc, cin1);
      check_outputs($sformatf("rnd%0d", i), e);
      expect_drop($sformatf("rnd%0d", i));
    end

    // start held high through RUN and DONE is ignored
    e = ref_op(CINS_ADDC, 16'h1234, 16'h1111, 1'b0);
    @(negedge clk);
    op_a = 16'h1234; op_b = 16'h1111; op_cins = CINS_ADDC; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 op_a = 16'hAAAA; op_b = 16'h5555;
    dones = 0;
    for (int n = 1; n <= NB + 1; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    start = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("ignored start done count", 64'(dones), 64'd1);
    check_outputs("ignored start", e);

    // Reset during RUN at idx=1
    @(negedge clk);
    op_a = 16'h0101; op_b = 16'h0101; op_cins = CINS_ADDC; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre-abort busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort outputs", 64'({result, flag_c, flag_v, flag_z, flag_n, flag_cmp, busy, done}), 64'd0);
    check("abort alu bus", 64'({alu_a, alu_b, alu_cins, alu_oe, alu_carryin}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("abort no done", 64'(dones), 64'd0);
    run_op("post-abort", vecs[2].cins, vecs[2].a, vecs[2].b, vecs[2].cin, cin1);
    check_outputs("post-abort",
                  '{r: vecs[2].r, c: vecs[2].c, v: vecs[2].v, z: vecs[2].z, n: vecs[2].n, cmp: vecs[2].cmp});
    expect_drop("post-abort");

`ifdef ALU_SEQ_HOLD_EN
    // DONE holds until result_ready; a start in the release cycle is ignored
    result_ready = 1'b0;
    run_op("hold", vecs[0].cins, vecs[0].a, vecs[0].b, vecs[0].cin, cin1);
    for (int n = 2; n <= 5; n++) begin
      @(negedge clk);
      check($sformatf("hold done cycle %0d", n), 64'(done), 64'd1);
    end
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("hold release done/busy", 64'({done, busy}), 64'd0);
    start = 1'b0;
    @(negedge clk);
    check("hold start ignored", 64'({done, busy}), 64'd0);
    check_outputs("hold",
                  '{r: vecs[0].r, c: vecs[0].c, v: vecs[0].v, z: vecs[0].z, n: vecs[0].n, cmp: vecs[0].cmp});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
